// File: rtl/unidade_controle_multiciclo_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : ctrl_pkg                                                   |
// | Description : Shared opcodes, FSM state codes, ALU codes and the         |
// |               instruction-class decoder for unidade_controle_multiciclo. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

  // RV64 major opcodes handled by the control unit
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Only doubleword loads/stores exist on this datapath
  localparam logic [2:0] F3_DOUBLE = 3'b011;

  // FSM state encodings (exported on the estado debug port)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  // ALU operation codes
  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0001;
  localparam logic [3:0] ULA_SLT = 4'b0010;
  localparam logic [3:0] ULA_EQU = 4'b0011;
  localparam logic [3:0] ULA_AND = 4'b0100;
  localparam logic [3:0] ULA_OR  = 4'b0101;
  localparam logic [3:0] ULA_XOR = 4'b0110;

  // rd source select
  localparam logic [1:0] RD_ULA = 2'b00;
  localparam logic [1:0] RD_MEM = 2'b01;
  localparam logic [1:0] RD_PC  = 2'b10;

  // Instruction class: decides which states the FSM walks through
  typedef enum logic [2:0] {
    K_NOP    = 3'd0,
    K_ALU    = 3'd1,
    K_LOAD   = 3'd2,
    K_STORE  = 3'd3,
    K_BRANCH = 3'd4,
    K_HALT   = 3'd5
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic       illegal;
    logic [3:0] op_ula;
    logic       sign;
    logic       ula_entry;
    logic [1:0] op_type;
    logic       branch;
    logic       auipc;
    logic       jal;
    logic       jalr;
  } decode_t;

  // Maps opcode/funct3/funct7[5] to the datapath controls. Illegal encodings
  // come back as an all-zero NOP with the illegal flag raised.
  function automatic decode_t decode_instr(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic       f7b5);
    decode_t d;
    d.kind      = K_NOP;
    d.illegal   = 1'b0;
    d.op_ula    = ULA_ADD;
    d.sign      = 1'b0;
    d.ula_entry = 1'b0;
    d.op_type   = RD_ULA;
    d.branch    = 1'b0;
    d.auipc     = 1'b0;
    d.jal       = 1'b0;
    d.jalr      = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        d.kind      = K_ALU;
        d.ula_entry = (opcode == OPC_OP);
        case (funct3)
          3'b000: d.op_ula = (opcode == OPC_OP && f7b5) ? ULA_SUB : ULA_ADD;
          3'b010: begin d.op_ula = ULA_SLT; d.sign = 1'b1; end
          3'b011: d.op_ula = ULA_SLT;
          3'b100: d.op_ula = ULA_XOR;
          3'b110: d.op_ula = ULA_OR;
          3'b111: d.op_ula = ULA_AND;
          default: d.illegal = 1'b1;   // shift encodings have no ula operation
        endcase
      end
      OPC_LOAD: begin
        d.kind    = K_LOAD;
        d.op_type = RD_MEM;
        d.sign    = 1'b1;
        d.illegal = (funct3 != F3_DOUBLE);
      end
      OPC_STORE: begin
        d.kind    = K_STORE;
        d.illegal = (funct3 != F3_DOUBLE);
      end
      OPC_BRANCH: begin
        d.kind      = K_BRANCH;
        d.branch    = 1'b1;
        d.ula_entry = 1'b1;
        case (funct3)
          3'b000, 3'b001: d.op_ula = ULA_EQU;
          3'b100, 3'b101: begin d.op_ula = ULA_SLT; d.sign = 1'b1; end
          3'b110, 3'b111: d.op_ula = ULA_SLT;
          default:        d.illegal = 1'b1;
        endcase
      end
      OPC_JAL:    begin d.kind = K_ALU; d.op_type = RD_PC; d.jal   = 1'b1; end
      OPC_JALR:   begin d.kind = K_ALU; d.op_type = RD_PC; d.jalr  = 1'b1; end
      OPC_AUIPC:  begin d.kind = K_ALU; d.op_type = RD_PC; d.auipc = 1'b1; end
      OPC_SYSTEM: d.kind = K_HALT;
      default:    d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.kind      = K_NOP;
      d.op_ula    = ULA_ADD;
      d.sign      = 1'b0;
      d.ula_entry = 1'b0;
      d.op_type   = RD_ULA;
      d.branch    = 1'b0;
      d.auipc     = 1'b0;
      d.jal       = 1'b0;
      d.jalr      = 1'b0;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_controle_multiciclo_gerador_imediato.sv
// +--------------------------------------------------------------------------+
// | Module      : gerador_imediato                                           |
// | Description : Combinational immediate generator (I/S/B/U/J formats),     |
// |               sign-extended from the format's top bit to BITS+1.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module gerador_imediato
  import ctrl_pkg::*;
#(
  parameter int BITS = 63
) (
  input  logic [31:0]   i_instr,
  output logic [BITS:0] o_imm
);

  localparam int c_W = BITS + 1;

  // Format chosen by opcode; everything not S/B/U/J uses the I layout
  always_comb begin
    o_imm = {{(c_W-12){i_instr[31]}}, i_instr[31:20]};
    case (i_instr[6:0])
      OPC_STORE:  o_imm = {{(c_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH: o_imm = {{(c_W-13){i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_AUIPC:  o_imm = {{(c_W-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      OPC_JAL:    o_imm = {{(c_W-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
      default:    ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
// +--------------------------------------------------------------------------+
// | Module      : unidade_controle_multiciclo                                |
// | Description : Multicycle FSM control unit for the RV64 datapath.         |
// |               FETCH -> DECODE -> EXEC -> [MEM] -> WB, HALT absorbing.    |
// |               Optional macro CTRL_ILLEGAL_TRAP_EN: illegal instructions  |
// |               halt the core and raise erro_instr (otherwise a NOP).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module unidade_controle_multiciclo
  import ctrl_pkg::*;
#(
  parameter int BITS = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instru,
  output logic          load_en,
  output logic          store_en,
  output logic [3:0]    op_ula,
  output logic [1:0]    operation_type,
  output logic          ula_entry,
  output logic          branch,
  output logic          auipc,
  output logic          jal,
  output logic          jalr,
  output logic          sign,
  output logic [BITS:0] imm_ext,
  output logic          pc_en,
  output logic          halted,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic          erro_instr,
`endif
  output logic [2:0]    estado
);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [31:0]   r_ir;
  kind_t         r_kind;
  logic [3:0]    r_op_ula;
  logic [1:0]    r_op_type;
  logic          r_ula_entry;
  logic          r_sign;
  logic          r_branch;
  logic          r_auipc;
  logic          r_jal;
  logic          r_jalr;
  logic [BITS:0] r_imm;
  logic [BITS:0] w_imm;
  decode_t       w_dec;
  logic          w_goto_halt;

  gerador_imediato #(.BITS(BITS)) u_imm (
    .i_instr (r_ir),
    .o_imm   (w_imm)
  );

  // Decode the latched instruction word
  always_comb begin
    w_dec = decode_instr(r_ir[6:0], r_ir[14:12], r_ir[30]);
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign w_goto_halt = (w_dec.kind == K_HALT) || w_dec.illegal;

  logic r_erro;

  // Sticky illegal-instruction flag, captured when the trap is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_erro <= 1'b0;
    else if (r_state == ST_DECODE && w_dec.illegal)
      r_erro <= 1'b1;
  end

  assign erro_instr = r_erro;
`else
  // Illegal words are already mapped to K_NOP by the decoder
  assign w_goto_halt = (w_dec.kind == K_HALT) && !w_dec.illegal;
`endif

  // Next-state selection: the instruction class decides which states are visited
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = w_goto_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (r_kind)
          K_ALU:             w_next = ST_WB;
          K_LOAD, K_STORE:   w_next = ST_MEM;
          default:           w_next = ST_FETCH;  // branch and NOP end here
        endcase
      end
      ST_MEM:    w_next = (r_kind == K_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_FETCH;
    else
      r_state <= w_next;
  end

  // Instruction register, loaded once per instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ir <= 32'd0;
    else if (r_state == ST_FETCH)
      r_ir <= instru;
  end

  // Decoded controls, held stable from EXEC until the next DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind      <= K_NOP;
      r_op_ula    <= ULA_ADD;
      r_op_type   <= RD_ULA;
      r_ula_entry <= 1'b0;
      r_sign      <= 1'b0;
      r_branch    <= 1'b0;
      r_auipc     <= 1'b0;
      r_jal       <= 1'b0;
      r_jalr      <= 1'b0;
      r_imm       <= '0;
    end else if (r_state == ST_DECODE) begin
      r_kind      <= w_dec.kind;
      r_op_ula    <= w_dec.op_ula;
      r_op_type   <= w_dec.op_type;
      r_ula_entry <= w_dec.ula_entry;
      r_sign      <= w_dec.sign;
      r_branch    <= w_dec.branch;
      r_auipc     <= w_dec.auipc;
      r_jal       <= w_dec.jal;
      r_jalr      <= w_dec.jalr;
      r_imm       <= w_imm;
    end
  end

  // Pulses are decoded from the state register so they last exactly one cycle
  // and vanish the moment reset forces the FSM back to FETCH.
  assign load_en  = (r_state == ST_WB);
  assign store_en = (r_state == ST_MEM) && (r_kind == K_STORE);
  assign pc_en    = (r_state == ST_WB)
                 || ((r_state == ST_MEM)  && (r_kind == K_STORE))
                 || ((r_state == ST_EXEC) && ((r_kind == K_BRANCH) || (r_kind == K_NOP)));
  assign halted   = (r_state == ST_HALT);
  assign estado   = r_state;

  assign op_ula         = r_op_ula;
  assign operation_type = r_op_type;
  assign ula_entry      = r_ula_entry;
  assign sign           = r_sign;
  assign branch         = r_branch;
  assign auipc          = r_auipc;
  assign jal            = r_jal;
  assign jalr           = r_jalr;
  assign imm_ext        = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_unidade_controle_multiciclo                             |
// | Description : Self-checking bench for unidade_controle_multiciclo.       |
// |               Honours CTRL_ILLEGAL_TRAP_EN when defined.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_unidade_controle_multiciclo;

  localparam int BITS = 63;

  logic          clk;
  logic          reset;
  logic [31:0]   instru;
  logic          load_en, store_en, ula_entry, branch, auipc, jal, jalr, sign, pc_en, halted;
  logic [3:0]    op_ula;
  logic [1:0]    operation_type;
  logic [BITS:0] imm_ext;
  logic [2:0]    estado;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic          erro_instr;
`endif

  unidade_controle_multiciclo #(.BITS(BITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .instru         (instru),
    .load_en        (load_en),
    .store_en       (store_en),
    .op_ula         (op_ula),
    .operation_type (operation_type),
    .ula_entry      (ula_entry),
    .branch         (branch),
    .auipc          (auipc),
    .jal            (jal),
    .jalr           (jalr),
    .sign           (sign),
    .imm_ext        (imm_ext),
    .pc_en          (pc_en),
    .halted         (halted),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .erro_instr     (erro_instr),
`endif
    .estado         (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entry per cycle: {estado[2:0], halted, load_en, store_en, pc_en}
  logic [6:0] exp_q[$];

  // Decode outputs captured during cycle 3 (EXEC) of the last instruction
  logic [3:0]    s_op;
  logic [1:0]    s_ot;
  logic          s_ue, s_br, s_sign, s_auipc, s_jal, s_jalr;
  logic [BITS:0] s_imm;

  function automatic void push_exp(input logic [2:0] st, input logic h,
                                   input logic l, input logic s, input logic p);
    exp_q.push_back({st, h, l, s, p});
  endfunction

  // Expected per-cycle trace of each instruction class
  function automatic void push_alu();   // OP, OP-IMM, JAL, JALR, AUIPC
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0);
    push_exp(3'd2,0,0,0,0); push_exp(3'd4,0,1,0,1);
  endfunction
  function automatic void push_load();
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0); push_exp(3'd2,0,0,0,0);
    push_exp(3'd3,0,0,0,0); push_exp(3'd4,0,1,0,1);
  endfunction
  function automatic void push_store();
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0);
    push_exp(3'd2,0,0,0,0); push_exp(3'd3,0,0,1,1);
  endfunction
  function automatic void push_short(); // branch or NOP: ends in EXEC
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0); push_exp(3'd2,0,0,0,1);
  endfunction

  // Scoreboard consumer: one pop-and-compare per cycle, sampled at negedge
  task automatic run_cycles(input int n, input string tag);
    logic [6:0] exp_v, act_v;
    for (int c = 1; c <= n; c++) begin
      act_v = {estado, halted, load_en, store_en, pc_en};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s cycle %0d: scoreboard empty, actual %b", tag, c, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v)
          $display("FAIL %s cycle %0d: {estado,halted,load,store,pc} actual %b required %b",
                   tag, c, act_v, exp_v);
        else
          n_pass++;
      end
      if (c == 3) begin
        s_op = op_ula; s_ot = operation_type; s_ue = ula_entry; s_br = branch;
        s_sign = sign; s_auipc = auipc; s_jal = jal; s_jalr = jalr; s_imm = imm_ext;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    instru = 32'h002081B3;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({estado, load_en, store_en, pc_en, halted, op_ula, operation_type, ula_entry,
         branch, auipc, jal, jalr, sign, imm_ext} !== '0)
      $display("FAIL reset_outputs: estado %0d load %b store %b pc %b halted %b op %b imm %h required all zero",
               estado, load_en, store_en, pc_en, halted, op_ula, imm_ext);
    else
      n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    instru = 32'h002081B3;                 // add x3,x1,x2
    push_alu();
    run_cycles(4, "add");
    n_checks++;
    if ({s_op, s_ue, s_ot} !== {4'b0000, 1'b1, 2'b00})
      $display("FAIL add_decode: op/ue/ot actual %b/%b/%b required 0000/1/00", s_op, s_ue, s_ot);
    else n_pass++;
  endtask

  task automatic test_load_store();
    instru = 32'h0080B283;                 // ld x5,8(x1)
    push_load();
    run_cycles(5, "ld");
    n_checks++;
    if ({s_imm, s_ue, s_ot} !== {64'd8, 1'b0, 2'b01})
      $display("FAIL ld_decode: imm/ue/ot actual %h/%b/%b required 8/0/01", s_imm, s_ue, s_ot);
    else n_pass++;
    instru = 32'h0050B823;                 // sd x5,16(x1)
    push_store();
    run_cycles(4, "sd");
    n_checks++;
    if ({s_imm, s_ue} !== {64'd16, 1'b0})
      $display("FAIL sd_decode: imm/ue actual %h/%b required 10/0", s_imm, s_ue);
    else n_pass++;
  endtask

  task automatic test_branch();
    instru = 32'hFE208EE3;                 // beq x1,x2,-4 (B-type encoding of -4)
    push_short();
    run_cycles(3, "beq");
    n_checks++;
    if ({s_imm, s_op, s_br} !== {64'hFFFF_FFFF_FFFF_FFFC, 4'b0011, 1'b1})
      $display("FAIL beq_decode: imm/op/br actual %h/%b/%b required fffffffffffffffc/0011/1",
               s_imm, s_op, s_br);
    else n_pass++;
    instru = 32'h0020C463;                 // blt x1,x2,8
    push_short();
    run_cycles(3, "blt");
    n_checks++;
    if ({s_imm, s_op, s_sign, s_br} !== {64'd8, 4'b0010, 1'b1, 1'b1})
      $display("FAIL blt_decode: imm/op/sign/br actual %h/%b/%b/%b required 8/0010/1/1",
               s_imm, s_op, s_sign, s_br);
    else n_pass++;
    instru = 32'h0020E463;                 // bltu x1,x2,8
    push_short();
    run_cycles(3, "bltu");
    n_checks++;
    if ({s_op, s_sign} !== {4'b0010, 1'b0})
      $display("FAIL bltu_decode: op/sign actual %b/%b required 0010/0", s_op, s_sign);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    instru = 32'h402081B3;                 // sub x3,x1,x2
    push_alu();
    run_cycles(4, "sub");
    n_checks++;
    if ({s_op, s_ue} !== {4'b0001, 1'b1})
      $display("FAIL sub_decode: op/ue actual %b/%b required 0001/1", s_op, s_ue);
    else n_pass++;
    instru = 32'hFFF0A213;                 // slti x4,x1,-1
    push_alu();
    run_cycles(4, "slti");
    n_checks++;
    if ({s_imm, s_op, s_sign, s_ue, s_ot} !== {{64{1'b1}}, 4'b0010, 1'b1, 1'b0, 2'b00})
      $display("FAIL slti_decode: imm/op/sign/ue/ot actual %h/%b/%b/%b/%b required ffffffffffffffff/0010/1/0/00",
               s_imm, s_op, s_sign, s_ue, s_ot);
    else n_pass++;
    instru = 32'h12345297;                 // auipc x5,0x12345
    push_alu();
    run_cycles(4, "auipc");
    n_checks++;
    if ({s_imm, s_auipc, s_ot} !== {64'h12345000, 1'b1, 2'b10})
      $display("FAIL auipc_decode: imm/auipc/ot actual %h/%b/%b required 12345000/1/10",
               s_imm, s_auipc, s_ot);
    else n_pass++;
    instru = 32'h008000EF;                 // jal x1,8
    push_alu();
    run_cycles(4, "jal");
    n_checks++;
    if ({s_imm, s_jal, s_jalr, s_ot} !== {64'd8, 1'b1, 1'b0, 2'b10})
      $display("FAIL jal_decode: imm/jal/jalr/ot actual %h/%b/%b/%b required 8/1/0/10",
               s_imm, s_jal, s_jalr, s_ot);
    else n_pass++;
  endtask

  task automatic test_illegal();
    instru = 32'hFFFFFFFF;
`ifdef CTRL_ILLEGAL_TRAP_EN
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0);
    for (int i = 0; i < 4; i++) push_exp(3'd7,1,0,0,0);
    run_cycles(6, "illegal_trap");
    n_checks++;
    if (erro_instr !== 1'b1)
      $display("FAIL illegal_erro: erro_instr actual %b required 1", erro_instr);
    else n_pass++;
    do_reset();
    n_checks++;
    if (erro_instr !== 1'b0)
      $display("FAIL illegal_erro_clear: erro_instr actual %b required 0", erro_instr);
    else n_pass++;
`else
    push_short();
    run_cycles(3, "illegal_nop");
    n_checks++;
    if ({s_br, s_auipc, s_jal, s_jalr} !== 4'b0000)
      $display("FAIL illegal_strobes: br/auipc/jal/jalr actual %b required 0000",
               {s_br, s_auipc, s_jal, s_jalr});
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_load();
    instru = 32'h0080B283;                 // ld x5,8(x1)
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0); push_exp(3'd2,0,0,0,0);
    run_cycles(3, "ld_abort");
    reset = 1'b1;                          // cycle 4, one cycle before WB
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({estado, load_en, pc_en} !== 5'b000_0_0)
        $display("FAIL ld_abort_%0d: estado/load/pc actual %0d/%b/%b required 0/0/0",
                 i, estado, load_en, pc_en);
      else n_pass++;
      @(negedge clk);
    end
    instru = 32'h002081B3;
    reset  = 1'b0;
    push_alu();
    run_cycles(4, "after_abort");
  endtask

  task automatic test_halt();
    instru = 32'h00000073;                 // ecall
    push_exp(3'd0,0,0,0,0); push_exp(3'd1,0,0,0,0);
    for (int i = 0; i < 21; i++) push_exp(3'd7,1,0,0,0);
    run_cycles(23, "ecall");
    #2 reset = 1'b1;                       // asynchronous, mid-cycle
    #1;
    n_checks++;
    if ({halted, estado} !== 4'b0_000)
      $display("FAIL halt_async_reset: halted/estado actual %b/%0d required 0/0", halted, estado);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    instru = 32'd0;
    test_reset();
    test_add();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid_load();
    test_halt();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
